// File: rtl/spi_master_core.sv
// SPI master for a single slave: one MSB-first full-duplex frame per start.
// CPOL/CPHA and bit rate fixed at elaboration.
module spi_master_core #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int SPI_FREQ   = 5_000_000,
  parameter int DATA_WIDTH = 8,
  parameter bit CPOL       = 1'b0,
  parameter bit CPHA       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] data_send,
  input  logic                  spi_start,
  output logic                  sclk,
  output logic                  csn,
  output logic                  mosi,
  input  logic                  miso,
  output logic                  spi_done,
  output logic [DATA_WIDTH-1:0] data_recv
);

  localparam int W    = DATA_WIDTH;
  localparam int HALF = CLK_FREQ / (2 * SPI_FREQ);
  localparam int DIVW = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int EW   = $clog2(2 * W + 1);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [DIVW-1:0] div_cnt;
  logic [EW-1:0]   edge_cnt;
  logic [EW-1:0]   edge_nxt;
  logic            sclk_r;
  logic [W-1:0]    tx;
  logic [W-1:0]    rx;
  logic [W-1:0]    recv;
  logic            tick;
  logic            last;
  logic            lead;
  logic            do_shift;
  logic            do_cap;

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tick      = (state == XFER) && (div_cnt == DIVW'(HALF - 1));
    last      = (edge_cnt == EW'(2 * W));
    edge_nxt  = edge_cnt + 1'b1;
    lead      = edge_nxt[0];
    do_shift  = 1'b0;
    do_cap    = 1'b0;
    unique case (state)
      IDLE: if (spi_start) state_nxt = XFER;
      XFER: begin
        if (tick && last) begin
          state_nxt = DONE;
        end else if (tick) begin
          if (!CPHA) begin
            do_shift = !lead && (edge_nxt != EW'(2 * W));
            do_cap   = lead;
          end else begin
            do_shift = lead && (edge_nxt != EW'(1));
            do_cap   = !lead;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
      sclk_r   <= CPOL;
      tx       <= '0;
      rx       <= '0;
      recv     <= '0;
    end else begin
      if (state == IDLE && spi_start) begin
        tx       <= data_send;
        rx       <= '0;
        div_cnt  <= '0;
        edge_cnt <= '0;
        sclk_r   <= CPOL;
      end
      if (state == XFER) begin
        if (tick) begin
          div_cnt <= '0;
          // the hold period after the final edge reuses the divider
          if (!last) begin
            sclk_r   <= ~sclk_r;
            edge_cnt <= edge_nxt;
          end
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
      if (do_shift) tx <= {tx[W-2:0], 1'b0};
      if (do_cap)   rx <= {rx[W-2:0], miso};
      if (state == XFER && state_nxt == DONE) recv <= rx;
    end
  end

  assign sclk      = sclk_r;
  assign csn       = (state != XFER);
  assign mosi      = (state == XFER) & tx[W-1];
  assign spi_done  = (state == DONE);
  assign data_recv = recv;

endmodule

// File: tb/tb_spi_master_core.sv
// Bench for spi_master_core: mode 0 and mode 3 instances driven by a
// behavioural SPI slave and checked against frame-level expectations.
module tb_spi_master_core;

  localparam int W    = 8;
  localparam int HALF = 50_000_000 / (2 * 5_000_000);
  localparam int TEND = 1 + (2 * W + 1) * HALF;

  logic         clk = 1'b0;
  logic         rstn = 1'b0;
  logic [1:0]   start = '0;
  logic [1:0]   miso = '0;
  logic [W-1:0] ds0 = '0;
  logic [W-1:0] ds1 = '0;
  wire  [1:0]   sclk;
  wire  [1:0]   csn;
  wire  [1:0]   mosi;
  wire  [1:0]   done;
  wire  [W-1:0] recv0;
  wire  [W-1:0] recv1;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  spi_master_core #(.CPOL(1'b0), .CPHA(1'b0)) dut0 (
    .clk(clk), .rstn(rstn), .data_send(ds0), .spi_start(start[0]),
    .sclk(sclk[0]), .csn(csn[0]), .mosi(mosi[0]), .miso(miso[0]),
    .spi_done(done[0]), .data_recv(recv0)
  );

  spi_master_core #(.CPOL(1'b1), .CPHA(1'b1)) dut1 (
    .clk(clk), .rstn(rstn), .data_send(ds1), .spi_start(start[1]),
    .sclk(sclk[1]), .csn(csn[1]), .mosi(mosi[1]), .miso(miso[1]),
    .spi_done(done[1]), .data_recv(recv1)
  );

  function automatic logic [W-1:0] rv(int m);
    return (m == 1) ? recv1 : recv0;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic frame(int m, logic [W-1:0] data, logic [W-1:0] pat,
                       int abort_at, bit poke);
    int       edges, rises, idx, done_cyc;
    logic [W-1:0] got, r0;
    logic     cpol, ps, pm, pc;
    bit       bad_edge, bad_mosi, moved, aborted, anydone;
    cpol = (m == 1);
    r0 = rv(m);
    edges = 0; rises = 0; idx = -1; done_cyc = -1; got = '0;
    bad_edge = 0; bad_mosi = 0; moved = 0; aborted = 0; anydone = 0;
    @(posedge clk); #1;
    chk($sformatf("gap_m%0d", m), {30'd0, csn[m], done[m]}, 32'd2);
    if (m == 1) ds1 = data; else ds0 = data;
    start[m] = 1'b1;
    @(posedge clk); #1;
    start[m] = 1'b0;
    if (m == 1) ds1 = W'($urandom); else ds0 = W'($urandom);
    ps = cpol; pm = 1'b0; pc = 1'b1;
    for (int c = 1; c <= TEND + 30; c++) begin
      if (c > 1) begin @(posedge clk); #1; end
      if (poke && c == 30) start[m] = 1'b1;
      if (poke && c == 31) start[m] = 1'b0;
      if (c == 1) chk($sformatf("csn_fall_m%0d", m), {31'd0, csn[m]}, 32'd0);
      if (sclk[m] !== ps) begin
        edges++;
        if (c != 1 + edges * HALF) bad_edge = 1;
        if (sclk[m] === 1'b1) begin
          if (rises < W) got[W-1-rises] = mosi[m];
          rises++;
        end else begin
          if (idx >= 0 && idx < W) miso[m] = pat[idx];
          idx--;
        end
      end
      if (c > 1 && done[m] !== 1'b1 && mosi[m] !== pm &&
          !(ps === 1'b1 && sclk[m] === 1'b0)) bad_mosi = 1;
      if (csn[m] === 1'b0 && pc === 1'b1) begin
        if (m == 0) begin miso[m] = pat[W-1]; idx = W - 2; end
        else idx = W - 1;
      end
      if (done[m] === 1'b1) begin
        done_cyc = c;
        chk($sformatf("recv_m%0d", m), 32'(rv(m)), 32'(pat));
        break;
      end else if (rv(m) !== r0) moved = 1;
      if (c == abort_at) begin
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        chk($sformatf("abort_csn_m%0d", m), {31'd0, csn[m]}, 32'd1);
        chk($sformatf("abort_sclk_m%0d", m), {31'd0, sclk[m]}, {31'd0, cpol});
        chk($sformatf("abort_done_m%0d", m), {31'd0, done[m]}, 32'd0);
        chk($sformatf("abort_mosi_m%0d", m), {31'd0, mosi[m]}, 32'd0);
        aborted = 1;
        break;
      end
      ps = sclk[m]; pm = mosi[m]; pc = csn[m];
    end
    if (aborted) begin
      for (int c = 0; c < TEND + 10; c++) begin
        @(posedge clk); #1;
        if (done[m] === 1'b1) anydone = 1;
      end
      chk($sformatf("abort_nodone_m%0d", m), {31'd0, anydone}, 32'd0);
    end else begin
      chk($sformatf("done_cyc_m%0d", m), 32'(done_cyc), 32'(TEND));
      chk($sformatf("mosi_bits_m%0d", m), 32'(got), 32'(data));
      chk($sformatf("edges_m%0d", m), 32'(edges), 32'(2 * W));
      chk($sformatf("edge_time_m%0d", m), {31'd0, bad_edge}, 32'd0);
      chk($sformatf("mosi_shift_m%0d", m), {31'd0, bad_mosi}, 32'd0);
      chk($sformatf("recv_hold_m%0d", m), {31'd0, moved}, 32'd0);
    end
  endtask

  initial begin
    @(posedge clk); #1;
    chk("rst_sclk0", {31'd0, sclk[0]}, 32'd0);
    chk("rst_sclk1", {31'd0, sclk[1]}, 32'd1);
    chk("rst_csn", {30'd0, csn}, 32'd3);
    chk("rst_mosi", {30'd0, mosi}, 32'd0);
    chk("rst_done", {30'd0, done}, 32'd0);
    chk("rst_recv0", 32'(recv0), 32'd0);
    chk("rst_recv1", 32'(recv1), 32'd0);
    rstn = 1'b1;
    @(posedge clk); #1;

    frame(0, 8'hA5, 8'h3C, 0, 1'b0);
    frame(0, 8'h9A, W'($urandom), 0, 1'b1);
    frame(0, W'($urandom), W'($urandom), 0, 1'b0);
    frame(1, W'($urandom), 8'h5A, 0, 1'b0);
    frame(1, W'($urandom), W'($urandom), 0, 1'b1);
    frame(0, W'($urandom), W'($urandom), 40, 1'b0);
    frame(0, W'($urandom), W'($urandom), 0, 1'b0);
    frame(1, W'($urandom), W'($urandom), 40, 1'b0);
    frame(1, W'($urandom), W'($urandom), 0, 1'b0);

    @(posedge clk); #1;
    chk("final_idle", {30'd0, csn}, 32'd3);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/spi_master_core.md
# spi_master_core

SPI bus master for a single slave. It serialises a `DATA_WIDTH`-bit word MSB-first on `mosi` and deserialises `miso` into `data_recv` at the same time. It sits between on-chip logic, which uses a one-cycle start pulse and a one-cycle done pulse, and the external SPI pins. Clock polarity, clock phase and bit rate are compile-time parameters.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000: system clock frequency in Hz.
- `SPI_FREQ`, 5_000_000: `sclk` frequency in Hz. `HALF = CLK_FREQ/(2*SPI_FREQ)` (integer division) must be ≥1.
- `DATA_WIDTH`, 8: bits per frame.
- `CPOL`, 0: idle level of `sclk`. 0 = idle low, 1 = idle high.
- `CPHA`, 0: clock phase.
  - 0: sample on the leading edge, shift on the trailing edge.
  - 1: shift on the leading edge, sample on the trailing edge.

Ports:
- `clk`, in, 1: system clock. Everything is on its rising edge. One clock domain.
- `rstn`, in, 1: reset. Synchronous and active-low.
- `data_send`, in, `DATA_WIDTH`: word to transmit. Latched in the cycle `spi_start` is accepted.
- `spi_start`, in, 1: start request, level-sampled. Accepted only in IDLE.
- `sclk`, out, 1: SPI clock.
- `csn`, out, 1: chip select, active low.
- `mosi`, out, 1: serial data out.
- `miso`, in, 1: serial data in.
- `spi_done`, out, 1: one-cycle pulse at the end of a frame.
- `data_recv`, out, `DATA_WIDTH`: received word.
  - Updated in the `spi_done` cycle.
  - Holds its value until the next `spi_done`.

## Operation
- Leading edge: the transition of `sclk` away from `CPOL`. Trailing edge: the transition back to `CPOL`.
- States: IDLE → XFER → DONE → IDLE.
- IDLE:
  - Outputs: `csn`=1, `sclk`=CPOL, `spi_done`=0.
  - On `spi_start`=1: latch `data_send` into the TX shift register, clear the divider and edge counters, go to XFER.
- XFER:
  - `csn`=0.
  - A divider counts `HALF` clk cycles. At each terminal count, toggle `sclk` and increment the edge counter.
  - Edges are numbered 1..2·`DATA_WIDTH`. Odd edges are leading, even edges are trailing.
- Bit order is MSB first in both directions. `mosi` is driven from the TX shift register MSB.
- CPHA=0:
  - `mosi` shows bit W-1 from the first XFER cycle.
  - The shift register advances on trailing edges 2, 4, …, 2W-2.
  - `miso` is captured on leading edges 1, 3, …, 2W-1.
- CPHA=1:
  - `mosi` shows bit W-1 from the first XFER cycle.
  - The shift register advances on leading edges 3, 5, …, 2W-1, so bit i is valid from its leading edge.
  - `miso` is captured on trailing edges 2, 4, …, 2W.
- Capture: the `miso` value present in the clk cycle that generates the edge is shifted into the LSB of the RX shift register.
- After edge 2W:
  - `sclk` is back at CPOL.
  - One further `HALF`-cycle hold period elapses with `csn`=0.
  - Then go to DONE.
- DONE, one cycle:
  - `csn`=1, `spi_done`=1, `data_recv` ← RX register.
  - Next cycle: IDLE.
- `spi_start` in XFER or DONE is ignored. It is not queued.
- `data_send` changes after the start is accepted do not affect the current frame.
- `mosi` = 0 in IDLE.

## Timing
- Reset, taking effect at the clk edge where `rstn`=0:
  - `sclk`=CPOL, `csn`=1, `mosi`=0, `spi_done`=0, `data_recv`=0, state = IDLE.
  - All counters and shift registers cleared.
- Reset mid-frame aborts immediately. No `spi_done` is produced.
- Cycle numbering: call the cycle in which `spi_start` is sampled in IDLE cycle 0.
  - `csn` falls at cycle 1.
  - Edge k appears at cycle 1 + k·HALF.
  - `spi_done`=1 and `csn` rises at cycle 1 + (2W+1)·HALF. With the defaults (HALF=5, W=8) this is cycle 86.
- `sclk` period is 2·HALF clk cycles, with a 50 % duty cycle.
- Back-to-back frames: a start asserted in the cycle after DONE is accepted, giving a minimum of 1 idle cycle with `csn`=1.

## Test plan
- Reset: hold `rstn`=0 for 1 cycle → `sclk`=0, `csn`=1, `mosi`=0, `spi_done`=0, `data_recv`=0.
- CPOL=0, CPHA=0, default rates, `data_send`=8'hA5 with a 1-cycle `spi_start`:
  - `mosi` at each `sclk` rising edge reads 1,0,1,0,0,1,0,1.
  - 8 rising edges are 10 clk cycles apart.
  - `spi_done` pulses once at cycle 86.
- Receive: slave drives `miso` on the falling edge with pattern 8'h3C MSB-first → `data_recv`=8'h3C in the `spi_done` cycle, and it stays stable afterwards.
- Back-to-back: start a second frame with 8'h9A 1 cycle after `spi_done` → MOSI reads 1,0,0,1,1,0,1,0 and a second `spi_done` occurs. Pulsing `spi_start` mid-frame causes no extra frame.
- CPOL=1, CPHA=1: `sclk` idles high.
  - `mosi` changes on falling edges.
  - `miso` (driven on falling edges) is sampled on rising edges.
  - Result `data_recv` = driven pattern 8'h5A.
- Reset at cycle 40 of a frame → next cycle `csn`=1, `sclk`=CPOL, no `spi_done`. A following frame completes normally.
